ram2_arbiter: RTL

//  Shares the single external SRAM (RAM2 bank) between instruction fetch (IF) and data access (MEM).
//  A registered FSM sequences SRAM read and write cycles on RAM2OE/RAM2WE/RAM2EN/RAM2ADDR/RAM2DATA.
//  MEM has fixed priority; stall outputs freeze the requesting pipeline stage until its access completes.

---
 rtl/ram2_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ram2_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : ram2_arbiter
// Brief   : Shares the RAM2 SRAM between IF fetch and MEM access (MEM priority),
//           sequencing registered SRAM read/write cycles.
// Rev     : 1.0  initial release
// =============================================================================
module ram2_arbiter #(
  parameter int RD_CYCLES = 1,
  parameter int WR_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_stall,
  output logic        RAM2OE,
  output logic        RAM2WE,
  output logic        RAM2EN,
  output logic [17:0] RAM2ADDR,
  inout  wire  [15:0] RAM2DATA
);

  localparam int C_MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int C_CNT_W   = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;
  localparam logic [C_CNT_W-1:0] C_RD_LAST = C_CNT_W'(RD_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_WR_LAST = C_CNT_W'(WR_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 own_mem_q, own_mem_d;
  logic [15:0]          addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [15:0]          if_rdata_q, if_rdata_d;
  logic [15:0]          mem_rdata_q, mem_rdata_d;
  logic                 if_ack_q, if_ack_d;
  logic                 mem_ack_q, mem_ack_d;
  logic                 oe_q, we_q, en_q, drive_q;
  logic                 oe_d, we_d, en_d, drive_d;
  logic                 w_mem_elig, w_if_elig;

  // A requester whose ack is showing this cycle is not regranted on its still-high req.
  assign w_mem_elig = mem_req & ~mem_ack_q;
  assign w_if_elig  = if_req & ~if_ack_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_mem_d   = own_mem_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (w_mem_elig) begin
          own_mem_d = 1'b1;
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          state_d   = mem_we ? S_WR_SETUP : S_READ;
        end else if (w_if_elig) begin
          own_mem_d = 1'b0;
          addr_d    = if_addr;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == C_RD_LAST) begin
          state_d = S_IDLE;
          if (own_mem_q) begin
            mem_rdata_d = RAM2DATA;
            mem_ack_d   = 1'b1;
          end else begin
            if_rdata_d = RAM2DATA;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = '0;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == C_WR_LAST) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      S_WR_HOLD: begin
        state_d   = S_IDLE;
        mem_ack_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin controls are derived from the next state so the pins themselves are flops.
  always_comb begin
    en_d    = (state_d == S_IDLE);
    oe_d    = (state_d != S_READ);
    we_d    = (state_d != S_WR_PULSE);
    drive_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      own_mem_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      en_q        <= 1'b1;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_mem_q   <= own_mem_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      en_q        <= en_d;
      drive_q     <= drive_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_stall = mem_req & ~mem_ack_q;
  assign RAM2OE    = oe_q;
  assign RAM2WE    = we_q;
  assign RAM2EN    = en_q;
  assign RAM2ADDR  = {2'b00, addr_q};
  assign RAM2DATA  = drive_q ? wdata_q : 16'hzzzz;

endmodule
`default_nettype wire
